// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable saturating down-counter with a zero flag.
// Used both as the RAM latency timer and as the IF starvation counter.
module mem_arb_lat_cnt #(
  parameter int unsigned    W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= RST_VAL;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (dec_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-ported RAM between IF and MEM.
// Optional feature macro: ARB_STARVE_GUARD_EN (IF starvation guard).
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LAT          = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_ack_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              stall_o
);

  state_t            r_state;
  owner_t            r_owner;
  logic              r_if_live;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_if_ack;
  logic              r_mem_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;

  logic w_idle;
  logic w_grant_mem;
  logic w_grant_if;
  logic w_grant;
  logic w_lat_zero;
  logic w_if_forced;

  assign w_idle      = (r_state == IDLE);
  assign w_grant_mem = w_idle & mem_req_i & ~(if_req_i & w_if_forced);
  assign w_grant_if  = w_idle & if_req_i & ~w_grant_mem;
  assign w_grant     = w_grant_mem | w_grant_if;

  mem_arb_lat_cnt #(
    .W       (LAT_W),
    .RST_VAL ('0)
  ) u_lat_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_grant),
    .load_val_i (LAT_W'(LAT)),
    .dec_i      (r_state == WAIT),
    .zero_o     (w_lat_zero)
  );

`ifdef ARB_STARVE_GUARD_EN
  // Counts down from STARVE_LIMIT on each IF loss; zero means IF is owed a grant.
  mem_arb_lat_cnt #(
    .W       (LAT_W),
    .RST_VAL (LAT_W'(STARVE_LIMIT))
  ) u_starve_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_grant_if),
    .load_val_i (LAT_W'(STARVE_LIMIT)),
    .dec_i      (w_grant_mem & if_req_i),
    .zero_o     (w_if_forced)
  );
`else
  assign w_if_forced = 1'b0 && (STARVE_LIMIT != 0);
`endif

  // Arbitration FSM: grant in IDLE, time the RAM read in WAIT, pulse the ack in RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_if_live   <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_ram_en  <= 1'b0;
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner     <= w_grant_mem ? OWN_MEM : OWN_IF;
            r_if_live   <= w_grant_if;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_grant_mem & mem_we_i;
            r_ram_addr  <= w_grant_mem ? mem_addr_i : if_addr_i;
            r_ram_wdata <= w_grant_mem ? mem_wdata_i : '0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          // A dropped IF request is a flush: the access completes silently.
          if ((r_owner == OWN_IF) && !if_req_i) begin
            r_if_live <= 1'b0;
          end
          if (w_lat_zero) begin
            if (r_owner == OWN_MEM) begin
              r_mem_ack <= 1'b1;
              if (!r_ram_we) begin
                r_mem_rdata <= ram_rdata_i;
              end
            end else if (r_if_live && if_req_i) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= ram_rdata_i;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_ack_o   = r_mem_ack;
  assign mem_rdata_o = r_mem_rdata;
  assign ram_en_o    = r_ram_en;
  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_wdata_o = r_ram_wdata;
  assign stall_o     = (if_req_i & ~r_if_ack) | (mem_req_i & ~r_mem_ack);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one LAT=1 instance, one LAT=3 instance.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- LAT=1 instance ----------------
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_ack, mem_ack, ram_en, ram_we, stall;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [31:0] p1;
  logic [31:0] w1_addr, w1_data;

  // ---------------- LAT=3 instance ----------------
  logic        if_req3, mem_req3, mem_we3;
  logic [31:0] if_addr3, mem_addr3, mem_wdata3;
  logic        if_ack3, mem_ack3, ram_en3, ram_we3, stall3;
  logic [31:0] if_rdata3, mem_rdata3, ram_addr3, ram_wdata3, ram_rdata3;
  logic [31:0] p3_0, p3_1, p3_2;

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .STARVE_LIMIT(4)) u1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_ack_o(mem_ack), .mem_rdata_o(mem_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .stall_o(stall)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3), .STARVE_LIMIT(4)) u3 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req3), .if_addr_i(if_addr3), .if_ack_o(if_ack3), .if_rdata_o(if_rdata3),
    .mem_req_i(mem_req3), .mem_we_i(mem_we3), .mem_addr_i(mem_addr3), .mem_wdata_i(mem_wdata3),
    .mem_ack_o(mem_ack3), .mem_rdata_o(mem_rdata3),
    .ram_en_o(ram_en3), .ram_we_o(ram_we3), .ram_addr_o(ram_addr3), .ram_wdata_o(ram_wdata3),
    .ram_rdata_i(ram_rdata3), .stall_o(stall3)
  );

  // RAM models: read data appears LAT cycles after the strobe cycle; writes are recorded.
  always @(posedge clk) begin
    p1 <= ram_val(ram_addr);
    if (ram_en && ram_we) begin
      w1_addr <= ram_addr;
      w1_data <= ram_wdata;
    end
    p3_0 <= ram_val(ram_addr3);
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign ram_rdata  = p1;
  assign ram_rdata3 = p3_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the LAT=3 instance and measure cycles to its ack.
  task automatic u3_lat(input string tag, input logic is_mem, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    if (is_mem) begin
      mem_req3 = 1'b1; mem_we3 = we; mem_addr3 = addr; mem_wdata3 = wd;
    end else begin
      if_req3 = 1'b1; if_addr3 = addr;
    end
    while ((n < 20) && !got) begin
      tick;
      n++;
      if (is_mem ? mem_ack3 : if_ack3) got = 1'b1;
    end
    check({tag, "_latency"}, n, 32'd5);
    if (is_mem && !we) check({tag, "_rdata"}, mem_rdata3, exp_rd);
    if (!is_mem)       check({tag, "_rdata"}, if_rdata3, exp_rd);
    if (is_mem && we)  check({tag, "_we"}, {31'd0, ram_we3}, 32'd1);
    mem_req3 = 1'b0;
    if_req3  = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    int nif, nmem;
    if_req = 0; mem_req = 0; mem_we = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0;
    if_req3 = 0; mem_req3 = 0; mem_we3 = 0; if_addr3 = 0; mem_addr3 = 0; mem_wdata3 = 0;
    tick;
    tick;
    rst = 1'b0;

    // Reset state
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_acks", {30'd0, if_ack, mem_ack}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_rdata", if_rdata | mem_rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // IF-only load of 0x10
    if_req = 1; if_addr = 32'h10;
    #1 check("if_stall_c0", {31'd0, stall}, 32'd1);
    tick;
    check("if_en_c1", {31'd0, ram_en}, 32'd1);
    check("if_addr_c1", ram_addr, 32'h10);
    check("if_stall_c1", {31'd0, stall}, 32'd1);
    tick;
    check("if_en_c2", {31'd0, ram_en}, 32'd0);
    check("if_ack_c2", {31'd0, if_ack}, 32'd0);
    check("if_stall_c2", {31'd0, stall}, 32'd1);
    tick;
    check("if_ack_c3", {31'd0, if_ack}, 32'd1);
    check("if_rdata_c3", if_rdata, 32'h0050_0093);
    check("if_stall_c3", {31'd0, stall}, 32'd0);
    if_req = 0;
    tick;
    check("if_ack_c4", {31'd0, if_ack}, 32'd0);

    // Simultaneous requests: MEM store wins, IF follows
    mem_req = 1; mem_we = 1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h20;
    tick;
    check("both_en_c1", {31'd0, ram_en}, 32'd1);
    check("both_we_c1", {31'd0, ram_we}, 32'd1);
    check("both_addr_c1", ram_addr, 32'h40);
    check("both_wdata_c1", ram_wdata, 32'hDEAD_BEEF);
    tick;
    check("both_wr_addr", w1_addr, 32'h40);
    check("both_wr_data", w1_data, 32'hDEAD_BEEF);
    tick;
    check("both_acks_c3", {30'd0, if_ack, mem_ack}, 32'd1);
    check("store_keeps_rdata", mem_rdata, 32'd0);
    mem_req = 0; mem_we = 0;
    tick;
    tick;
    check("both_if_en_c5", {31'd0, ram_en}, 32'd1);
    check("both_if_we_c5", {31'd0, ram_we}, 32'd0);
    check("both_if_addr_c5", ram_addr, 32'h20);
    tick;
    check("both_if_ack_c6", {31'd0, if_ack}, 32'd0);
    tick;
    check("both_if_ack_c7", {31'd0, if_ack}, 32'd1);
    check("both_if_rdata", if_rdata, 32'hC0DE_0020);
    if_req = 0;
    tick;

    // Flush: IF drops its request in WAIT
    if_req = 1; if_addr = 32'h30;
    tick;
    check("flush_en_c1", {31'd0, ram_en}, 32'd1);
    if_req = 0;
    nif = 0;
    tick;
    check("flush_en_c2", {31'd0, ram_en}, 32'd0);
    if (if_ack) nif++;
    tick;
    if (if_ack) nif++;
    check("flush_no_ack", nif, 32'd0);
    check("flush_rdata_kept", if_rdata, 32'hC0DE_0020);
    tick;
    if_req = 1; if_addr = 32'h34;
    tick;
    check("flush_idle_en_c5", {31'd0, ram_en}, 32'd1);
    check("flush_idle_addr", ram_addr, 32'h34);
    tick;
    tick;
    check("flush_next_ack", {31'd0, if_ack}, 32'd1);
    check("flush_next_rdata", if_rdata, 32'hC0DE_0034);
    if_req = 0;
    tick;

    // Asynchronous reset mid-WAIT
    mem_req = 1; mem_we = 0; mem_addr = 32'h08;
    tick;
    check("arst_en_before", {31'd0, ram_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_en", {31'd0, ram_en}, 32'd0);
    check("arst_addr", ram_addr, 32'd0);
    check("arst_rdata", if_rdata | mem_rdata, 32'd0);
    mem_req = 0;
    tick;
    rst = 1'b0;
    nmem = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (mem_ack || if_ack || ram_en) nmem++;
    end
    check("arst_quiet_after", nmem, 32'd0);
    mem_req = 1; mem_we = 0; mem_addr = 32'h08;
    tick;
    check("arst_next_en", {31'd0, ram_en}, 32'd1);
    tick;
    tick;
    check("arst_next_ack", {31'd0, mem_ack}, 32'd1);
    check("arst_next_rdata", mem_rdata, 32'hC0DE_0008);
    mem_req = 0;
    tick;

    // Both requests held continuously for five transaction slots
    mem_req = 1; mem_we = 0; mem_addr = 32'h0C;
    if_req = 1; if_addr = 32'h50;
    nif = 0;
    nmem = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (if_ack) nif++;
      if (mem_ack) nmem++;
    end
    mem_req = 0;
    if_req = 0;
`ifdef ARB_STARVE_GUARD_EN
    check("starve_mem_grants", nmem, 32'd4);
    check("starve_if_grants", nif, 32'd1);
`else
    check("strict_mem_grants", nmem, 32'd5);
    check("strict_if_grants", nif, 32'd0);
`endif
    tick;
    tick;

    // LAT=3 latency sweep
    u3_lat("lat3_if_load", 1'b0, 1'b0, 32'h44, 32'd0, 32'hC0DE_0044);
    u3_lat("lat3_mem_load", 1'b1, 1'b0, 32'h4C, 32'd0, 32'hC0DE_004C);
    u3_lat("lat3_mem_store", 1'b1, 1'b1, 32'h48, 32'h1234_5678, 32'd0);
    check("lat3_store_keeps_rdata", mem_rdata3, 32'hC0DE_004C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
